// File: rtl/display_7seg_mux_if.sv
// Pin bundle between the data path and the multiplexed 7-segment driver.
// The master drives the value, strobes and controls; the slave returns the pin-level outputs.
interface display_7seg_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] dato_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic                  load_i;
  logic                  en_i;
  logic                  lzb_i;
  logic [6:0]            seg_o;
  logic                  dp_o;
  logic [N_DIGITS-1:0]   an_o;
  logic                  frame_o;

  modport master (
    output dato_i, dp_i, load_i, en_i, lzb_i,
    input  seg_o, dp_o, an_o, frame_o
  );

  modport slave (
    input  dato_i, dp_i, load_i, en_i, lzb_i,
    output seg_o, dp_o, an_o, frame_o
  );
endinterface

// File: rtl/display_7seg_mux.sv
// Time-multiplexed hex driver for N 7-segment digits with a double-buffered display value,
// per-digit decimal points, leading-zero blanking and a global anode enable.
module display_7seg_mux #(
  parameter int N_DIGITS   = 4,
  parameter int DIV        = 25000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  display_7seg_mux_if.slave  bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic                POL      = (ACTIVE_LOW != 0);
  localparam logic [6:0]          SEG_OFF  = {7{POL}};
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{POL}};

  // Segment pattern in active-low form {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
    return code;
  endfunction

  // Prescaler and scan index
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             tick;
  logic             wrap;

  // Pending (write side) and display (read side) buffers
  logic [DW-1:0]       pend_dato_reg, pend_dato_next;
  logic [N_DIGITS-1:0] pend_dp_reg, pend_dp_next;
  logic                pend_reg, pend_next;
  logic [DW-1:0]       disp_dato_reg, disp_dato_next;
  logic [N_DIGITS-1:0] disp_dp_reg, disp_dp_next;
  logic                commit;

  // Registered pin outputs
  logic [6:0]          seg_reg, seg_next;
  logic                dp_reg, dp_next;
  logic [N_DIGITS-1:0] an_reg, an_next;
  logic                frame_reg, frame_next;

  // Per-digit decode of the value about to be displayed
  logic [3:0]          digit_nib [N_DIGITS];
  logic [N_DIGITS:0]   zero_above;
  logic [N_DIGITS-1:0] blank;
  logic [N_DIGITS-1:0] an_onehot;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                cur_dp;
  logic [6:0]          seg_hi;

  always_comb begin
    tick     = (cnt_reg == CNT_LAST);
    cnt_next = tick ? '0 : cnt_reg + 1'b1;
    wrap     = tick && (idx_reg == IDX_LAST);
    if (wrap) begin
      idx_next = '0;
    end else if (tick) begin
      idx_next = idx_reg + 1'b1;
    end else begin
      idx_next = idx_reg;
    end
  end

  // A load coinciding with the commit still lands in pending; the commit takes the old content.
  always_comb begin
    commit         = wrap && pend_reg;
    disp_dato_next = commit ? pend_dato_reg : disp_dato_reg;
    disp_dp_next   = commit ? pend_dp_reg   : disp_dp_reg;
    pend_dato_next = pend_dato_reg;
    pend_dp_next   = pend_dp_reg;
    pend_next      = pend_reg;
    if (bus.load_i) begin
      pend_dato_next = bus.dato_i;
      pend_dp_next   = bus.dp_i;
      pend_next      = 1'b1;
    end else if (commit) begin
      pend_next      = 1'b0;
    end
  end

  assign zero_above[N_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign digit_nib[gi]  = disp_dato_next[4*gi +: 4];
      assign zero_above[gi] = (digit_nib[gi] == 4'h0) && zero_above[gi+1];
      assign an_onehot[gi]  = bus.en_i && (idx_next == IDX_W'(gi));
      if (gi == 0) begin : g_first
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = bus.lzb_i && zero_above[gi];
      end
    end
  endgenerate

  // Internal polarity is active-high; POL flips everything at the pins.
  always_comb begin
    cur_nib    = digit_nib[idx_next];
    cur_blank  = blank[idx_next];
    cur_dp     = disp_dp_next[idx_next];
    seg_hi     = cur_blank ? 7'b0000000 : ~hex_to_seg_n(cur_nib);
    seg_next   = POL ? ~seg_hi    : seg_hi;
    dp_next    = POL ? ~cur_dp    : cur_dp;
    an_next    = POL ? ~an_onehot : an_onehot;
    frame_next = wrap;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      pend_dato_reg <= '0;
      pend_dp_reg   <= '0;
      pend_reg      <= 1'b0;
      disp_dato_reg <= '0;
      disp_dp_reg   <= '0;
      seg_reg       <= SEG_OFF;
      dp_reg        <= POL;
      an_reg        <= AN_OFF;
      frame_reg     <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      pend_dato_reg <= pend_dato_next;
      pend_dp_reg   <= pend_dp_next;
      pend_reg      <= pend_next;
      disp_dato_reg <= disp_dato_next;
      disp_dp_reg   <= disp_dp_next;
      seg_reg       <= seg_next;
      dp_reg        <= dp_next;
      an_reg        <= an_next;
      frame_reg     <= frame_next;
    end
  end

  assign bus.seg_o   = seg_reg;
  assign bus.dp_o    = dp_reg;
  assign bus.an_o    = an_reg;
  assign bus.frame_o = frame_reg;

endmodule
